mux16_rr_scheduler: RTL
=======================

Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler that shares the 16:1 single-bit multiplexer (mux16x1) among 16 requesters.
- Drives the mux select and a one-hot grant vector.
- Holds each grant until the requester releases it or a hold limit expires.
- Sits directly in front of mux16x1: its sel output connects to the mux sel port, and each requester's data bit feeds the matching mux input.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- en  input  1  scheduler enable. While low, no new grant is issued and any current grant is released.
- req  input  16  request lines. req[i] high means requester i wants the mux.
- gnt  output  16  one-hot grant. All zeros when no grant is active.
- sel  output  4  mux select, equal to the index of the granted requester
- gnt_valid  output  1  high while a grant is active
- preempt  output  1  one-cycle pulse when a grant ends by hold timeout

Behaviour:
- Reset (async, rst=1), forced immediately, regardless of clock or state:
  - state=IDLE, gnt=0, sel=0, gnt_valid=0, preempt=0, hold_cnt=0.
  - Last-granted pointer last=15, so requester 0 has first priority after reset.
- All other updates occur on the rising edge of clk. All outputs are registered.
- State IDLE:
  - If en=1 and req!=0, search req from index (last+1) mod 16 upward, wrapping 15 to 0. Pick the first set bit k.
  - Next edge: state=GRANT, gnt=1<<k, sel=k, gnt_valid=1, last=k, hold_cnt=0.
  - Latency: 1 cycle from req sampled high to gnt visible.
  - Otherwise stay in IDLE. sel keeps its previous value, so the mux output stays stable.
- State GRANT, each edge, in this priority order:
  1. If en=0 or req[sel]=0: release. Next state IDLE, gnt=0, gnt_valid=0, preempt=0.
  2. Else if hold_cnt==MAX_HOLD-1: release by timeout. Next state IDLE, gnt=0, gnt_valid=0, preempt=1 for exactly one cycle.
  3. Else stay in GRANT with hold_cnt+1.
- Maximum grant length is MAX_HOLD cycles with gnt_valid high.
- Every release is followed by at least one IDLE cycle with gnt=0, so there are no back-to-back grants without a gap.
  - Minimum re-grant period is 2 cycles.
  - sel changes only on the edge that enters GRANT.
- Fairness: the granted index becomes lowest priority. With all 16 requesting continuously, grants go 0,1,…,15,0 and no requester waits more than 15 grants.
- preempt: 0 in all cycles except the single cycle after a timeout release.
- Simultaneous events:
  - If req[sel] drops on the same edge hold_cnt reaches MAX_HOLD-1, the normal release wins and preempt=0.
  - Changes to req bits other than the granted bit have no effect during GRANT.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. If the requester still holds req, preempt pulses after each grant.
- hold_cnt is 8 bits wide and never wraps, because it is cleared at every grant.
- Invariants, checked by assertion:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - When gnt_valid=1, gnt[sel]=1.

Test Plan:
- Reset, then req=16'h0001, en=1: after 1 cycle gnt=16'h0001, sel=0, gnt_valid=1. Drop req: next cycle gnt=0, gnt_valid=0, preempt=0.
- req=16'hFFFF held, en=1, MAX_HOLD=1: sel sequence 0,1,2,…,15,0 with a 1-cycle gap between grants. preempt pulses after every grant.
- req=16'h8001 held, MAX_HOLD=8: requester 0 granted for exactly 8 cycles, then preempt=1 for 1 cycle, one IDLE cycle, then sel=15 granted for 8 cycles, then back to 0.
- Grant active on sel=5, assert rst asynchronously mid-cycle: gnt, gnt_valid and sel clear to 0 before the next edge. After release, with req=16'h0020, the first grant is again sel=5, because last was reset to 15.
- en=0 with req=16'h0010: no grant for 10 cycles. Raise en: gnt=16'h0010 after 1 cycle. Drop en while granted: release next edge, preempt=0.
- Integrate with mux16x1: drive mux in=16'b1<<k from requester k's data. Check that mux out equals 1 in every cycle where gnt_valid=1.

Source files
------------

// File: rtl/mux16_rr_scheduler.sv
// Round-robin arbiter owning the select of a shared 16:1 single-bit mux.
// Grants are held until release or MAX_HOLD cycles, with one idle cycle between grants.
module mux16_rr_scheduler #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic        preempt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] gnt_q, gnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  hold_q, hold_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        preempt_q, preempt_d;

  logic        found;
  logic [3:0]  pick;
  logic [3:0]  idx;

  // Offset 16 wraps back onto last itself, so it is searched last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= 16; i++) begin
      idx = last_q + 4'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d     = GRANT;
          gnt_d       = 16'h1 << pick;
          sel_d       = pick;
          last_d      = pick;
          hold_d      = '0;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (!en || !req[sel_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      last_q      <= 4'd15;
      hold_q      <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid:  assert property (@(posedge clk) disable iff (rst) gnt_valid_q == (|gnt_q));
  a_sel:    assert property (@(posedge clk) disable iff (rst) gnt_valid_q |-> gnt_q[sel_q]);

endmodule
